// File: rtl/fadd_issue.sv
// Issue/writeback wrapper in front of the LAT-stage fadd pipeline: credit-gated issue, in-flight tag tracking, result FIFO.
// Optional macro FADD_ISSUE_OVF_STICKY_EN adds ovf_clr/ovf_sticky (sticky overflow flag).
module fadd_issue #(
  parameter int TAG_W      = 6,
  parameter int LAT        = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_sub,
  input  logic [31:0]      req_x1,
  input  logic [31:0]      req_x2,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      fa_x1,
  output logic [31:0]      fa_x2,
  input  logic [31:0]      fa_y,
  input  logic             fa_ovf,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_y,
  output logic             resp_ovf,
  output logic [TAG_W-1:0] resp_tag
`ifdef FADD_ISSUE_OVF_STICKY_EN
  ,
  input  logic             ovf_clr,
  output logic             ovf_sticky
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = $clog2(LAT + FIFO_DEPTH + 1);
  localparam int EW = 1 + 32 + TAG_W;

  logic [LAT-1:0]   vsr;
  logic [TAG_W-1:0] tsr [LAT];
  logic [EW-1:0]    mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [OW-1:0]    in_flight;
  logic [OW-1:0]    outstanding;
  logic             fire;
  logic             push;
  logic             pop;

  assign fa_x1 = req_x1;
  assign fa_x2 = {req_x2[31] ^ req_sub, req_x2[30:0]};

  assign fire = req_valid & req_ready;
  assign push = vsr[LAT-1];
  assign pop  = resp_valid & resp_ready;

  // Valid/tag shadow of the fadd pipeline; fadd cannot stall, so this only ever shifts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsr <= '0;
      for (int i = 0; i < LAT; i++) tsr[i] <= '0;
    end else begin
      vsr[0] <= fire;
      if (fire) tsr[0] <= req_tag;
      for (int i = 1; i < LAT; i++) begin
        vsr[i] <= vsr[i-1];
        tsr[i] <= tsr[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {fa_ovf, fa_y, tsr[LAT-1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign resp_valid = (count != '0);
  assign {resp_ovf, resp_y, resp_tag} = mem[rd_ptr];

  // Every in-flight op already owns a FIFO slot, so a capture can never find the FIFO full.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < LAT; i++) in_flight = in_flight + OW'(vsr[i]);
  end

  assign outstanding = in_flight + OW'(count);
  assign req_ready   = ~rst & (outstanding < OW'(FIFO_DEPTH));

`ifdef FADD_ISSUE_OVF_STICKY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 ovf_sticky <= 1'b0;
    else if (push && fa_ovf) ovf_sticky <= 1'b1;
    else if (ovf_clr)        ovf_sticky <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_fadd_issue.sv
// Scoreboard bench for fadd_issue with an integer-valued fadd stand-in; covers FADD_ISSUE_OVF_STICKY_EN when defined.
module tb_fadd_issue;

  localparam int TAG_W = 6;
  localparam int LAT   = 3;
  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0]      y;
    logic             ovf;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0, req_sub = 1'b0, resp_ready = 1'b0;
  logic [31:0] req_x1 = '0, req_x2 = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic req_ready, resp_valid, resp_ovf, fa_ovf;
  logic [31:0] fa_x1, fa_x2, fa_y, resp_y;
  logic [TAG_W-1:0] resp_tag;
`ifdef FADD_ISSUE_OVF_STICKY_EN
  logic ovf_clr = 1'b0;
  logic ovf_sticky;
`endif

  int vectors = 0;
  int miscompares = 0;
  exp_t sb[$];
  exp_t cur_exp;

  logic [32:0] pipe [LAT];

  always #5 clk = ~clk;

  fadd_issue #(.TAG_W(TAG_W), .LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_sub(req_sub),
    .req_x1(req_x1), .req_x2(req_x2), .req_tag(req_tag),
    .fa_x1(fa_x1), .fa_x2(fa_x2), .fa_y(fa_y), .fa_ovf(fa_ovf),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_y(resp_y), .resp_ovf(resp_ovf), .resp_tag(resp_tag)
`ifdef FADD_ISSUE_OVF_STICKY_EN
    , .ovf_clr(ovf_clr), .ovf_sticky(ovf_sticky)
`endif
  );

  function automatic logic [31:0] int_to_float(input int v);
    logic [31:0] mag;
    logic [31:0] m;
    int p;
    if (v == 0) return 32'd0;
    mag = (v < 0) ? 32'(-v) : 32'(v);
    p = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) p = i;
    m = (p <= 23) ? (mag << (23 - p)) : (mag >> (p - 23));
    return {v < 0, 8'(127 + p), m[22:0]};
  endfunction

  function automatic int float_to_int(input logic [31:0] f);
    int e;
    logic [31:0] mant;
    logic [31:0] mag;
    e = int'(f[30:23]) - 127;
    if (e < 0) return 0;
    mant = {8'd0, 1'b1, f[22:0]};
    mag = (e <= 23) ? (mant >> (23 - e)) : (mant << (e - 23));
    return f[31] ? -int'(mag) : int'(mag);
  endfunction

  // fadd stand-in: exact for integer-valued operands; huge operands saturate to inf with ovf.
  function automatic logic [32:0] stub_add(input logic [31:0] a, input logic [31:0] b);
    if (a[30:23] >= 8'd157 || b[30:23] >= 8'd157) return {1'b1, a[31], 8'hFF, 23'd0};
    return {1'b0, int_to_float(float_to_int(a) + float_to_int(b))};
  endfunction

  always @(posedge clk) begin
    pipe[0] <= stub_add(fa_x1, fa_x2);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign {fa_ovf, fa_y} = pipe[LAT-1];

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue tap: records the expected result of every accepted request.
  always @(negedge clk) begin
    if (rst) sb.delete();
    else if (req_valid && req_ready) sb.push_back(cur_exp);
  end

  // Monitor: every consumed response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst) check_output("resp_valid_in_reset", 64'(resp_valid), 64'd0);
    if (dut.vsr[LAT-1]) check_output("push_when_full", 64'(dut.count == DEPTH), 64'd0);
    if (resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        check_output("unexpected_resp", {25'd0, resp_ovf, resp_y, resp_tag}, 64'd0);
      end else begin
        e = sb.pop_front();
        check_output("resp", {25'd0, resp_ovf, resp_y, resp_tag}, {25'd0, e.ovf, e.y, e.tag});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_raw(input logic [31:0] x1, input logic [31:0] x2, input logic sub,
                           input logic [TAG_W-1:0] tag, input logic [31:0] ey, input logic eovf);
    req_valid = 1'b1;
    req_x1 = x1;
    req_x2 = x2;
    req_sub = sub;
    req_tag = tag;
    cur_exp.y = ey;
    cur_exp.ovf = eovf;
    cur_exp.tag = tag;
  endtask

  task automatic apply_stimulus(input int a, input int b, input logic sub, input logic [TAG_W-1:0] tag);
    apply_raw(int_to_float(a), int_to_float(b), sub, tag, int_to_float(sub ? a - b : a + b), 1'b0);
  endtask

  // Called at issue-cycle edge+2; resp_valid must appear exactly LAT+1 cycles later for one cycle.
  task automatic expect_latency(input string name);
    for (int k = 1; k <= LAT + 2; k++) begin
      tick();
      if (k == 1) req_valid = 1'b0;
      #1;
      check_output($sformatf("%s_rv_c%0d", name, k), 64'(resp_valid), 64'(k == LAT + 1));
    end
  endtask

  task automatic drain();
    req_valid = 1'b0;
    resp_ready = 1'b1;
    for (int k = 0; k < 100 && (sb.size() != 0 || resp_valid); k++) tick();
    check_output("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int fires;
    int t;
    logic fired;
    logic have_req;

    #2;
    check_output("reset_req_ready", 64'(req_ready), 64'd0);
    check_output("reset_resp_valid", 64'(resp_valid), 64'd0);
    tick(); tick();
    rst = 1'b0;
    #1;
    check_output("post_reset_req_ready", 64'(req_ready), 64'd1);

    // Single add, exact latency and one-cycle resp_valid.
    resp_ready = 1'b1;
    apply_raw(32'h3F800000, 32'h40000000, 1'b0, 6'd5, 32'h40400000, 1'b0);
    #1;
    check_output("add_fire", 64'(req_ready), 64'd1);
    expect_latency("add");

    // Subtract, with the sign flip visible on fa_x2.
    apply_raw(32'h40400000, 32'h3F800000, 1'b1, 6'd9, 32'h40000000, 1'b0);
    #1;
    check_output("sub_fa_x2", 64'(fa_x2), 64'hBF800000);
    check_output("sub_fa_x1", 64'(fa_x1), 64'h40400000);
    expect_latency("sub");

    // Overflow pass-through and sticky flag.
    apply_raw(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 6'd33, 32'h7F800000, 1'b1);
    for (int k = 1; k <= LAT + 2; k++) begin
      tick();
      if (k == 1) req_valid = 1'b0;
      #1;
      check_output($sformatf("ovf_rv_c%0d", k), 64'(resp_valid), 64'(k == LAT + 1));
`ifdef FADD_ISSUE_OVF_STICKY_EN
      check_output($sformatf("ovf_sticky_c%0d", k), 64'(ovf_sticky), 64'(k >= LAT + 1));
`endif
    end
`ifdef FADD_ISSUE_OVF_STICKY_EN
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    #1;
    check_output("ovf_sticky_clr", 64'(ovf_sticky), 64'd0);
`endif
    drain();

    // Backpressure: only DEPTH ops may be outstanding.
    resp_ready = 1'b0;
    fires = 0;
    t = 1;
    for (int k = 0; k < 10; k++) begin
      apply_stimulus(10 * t, t, 1'b0, 6'(t));
      #1;
      fired = req_ready;
      tick();
      if (fired) begin
        fires++;
        t++;
      end
    end
    check_output("bp_fire_count", 64'(fires), 64'(DEPTH));
    check_output("bp_ready_low", 64'(req_ready), 64'd0);
    resp_ready = 1'b1;
    #1;
    check_output("bp_ready_on_first_pop", 64'(req_ready), 64'd0);
    tick();
    check_output("bp_ready_after_pop", 64'(req_ready), 64'd1);
    for (int k = 0; k < 20 && t <= 6; k++) begin
      apply_stimulus(10 * t, t, 1'b0, 6'(t));
      #1;
      fired = req_ready;
      tick();
      if (fired) t++;
    end
    check_output("bp_all_fired", 64'(t), 64'd7);
    drain();

    // Reset while ops are in flight: their results must never appear.
    apply_stimulus(100, 1, 1'b0, 6'd20);
    tick();
    apply_stimulus(200, 2, 1'b0, 6'd21);
    tick();
    apply_stimulus(300, 3, 1'b1, 6'd22);
    rst = 1'b1;
    #1;
    check_output("rst_mid_ready", 64'(req_ready), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    check_output("rst_release_ready", 64'(req_ready), 64'd1);
    expect_latency("rst_next");
    drain();

    // Randomized traffic with random backpressure.
    have_req = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (!have_req && $urandom_range(3) != 0) begin
        apply_stimulus(int'($urandom_range(2000)) - 1000, int'($urandom_range(2000)) - 1000,
                       1'($urandom_range(1)), 6'($urandom_range(63)));
        have_req = 1'b1;
      end
      req_valid = have_req;
      resp_ready = ($urandom_range(3) != 0);
      #1;
      fired = req_valid && req_ready;
      tick();
      if (fired) have_req = 1'b0;
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/fadd_issue.md
Name: fadd_issue

Overview:
Issue and writeback wrapper placed directly upstream of the 3-stage fadd pipeline.
- Accepts fadd/fsub requests from the core over a valid/ready handshake. For fsub, flips the sign bit of x2 before it enters fadd.
- Tracks each in-flight operation's valid bit and destination tag alongside fadd's non-stallable pipeline.
- Captures each result into an output FIFO. Credit-based issue control guarantees no result is ever dropped.

Parameters:
- TAG_W, 6: width of the destination tag (register number) carried with each operation.
- LAT, 3: cycles from fadd inputs presented to fadd y valid. Must equal the fadd pipeline depth.
- FIFO_DEPTH, 4: result FIFO entries. Also the maximum number of outstanding operations. Power of two, at least 2.

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: reset, asynchronous, active-high.
- req_valid, in, 1: request present.
- req_ready, out, 1: request accepted this cycle when high together with req_valid.
- req_sub, in, 1: 1 = x1 - x2, 0 = x1 + x2.
- req_x1, in, 32: IEEE-754 single-precision operand 1.
- req_x2, in, 32: IEEE-754 single-precision operand 2.
- req_tag, in, TAG_W: destination tag.
- fa_x1, out, 32: to fadd x1.
- fa_x2, out, 32: to fadd x2.
- fa_y, in, 32: from fadd y.
- fa_ovf, in, 1: from fadd ovf.
- resp_valid, out, 1: result available at FIFO head.
- resp_ready, in, 1: consumer takes the head result when high together with resp_valid.
- resp_y, out, 32: result value.
- resp_ovf, out, 1: overflow flag of the result.
- resp_tag, out, TAG_W: tag of the result.

Behaviour:
- Reset (asynchronous):
  - Valid/tag shift register (vsr/tsr, LAT entries) is cleared.
  - FIFO is emptied: pointers and count = 0.
  - resp_valid = 0.
  - req_ready = 0 while rst is high.
- Issue datapath:
  - fa_x1 = req_x1, combinational.
  - fa_x2 = {req_x2[31] ^ req_sub, req_x2[30:0]}, combinational. fadd registers its inputs internally.
  - fa_x1/fa_x2 are driven every cycle regardless of fire. Garbage entering fadd is harmless because vsr gates capture.
- Fire: fire = req_valid & req_ready. On fire, vsr[0] <= 1 and tsr[0] <= req_tag. Otherwise vsr[0] <= 0.
- Shift: every cycle, vsr[i] <= vsr[i-1] and tsr[i] <= tsr[i-1], for i = 1..LAT-1.
- Capture:
  - In any cycle with vsr[LAT-1] = 1, fa_y/fa_ovf are valid.
  - {fa_ovf, fa_y, tsr[LAT-1]} is pushed into the FIFO at the next edge.
- Latency:
  - Issue accepted in cycle 0 gives resp_valid in cycle LAT+1 (cycle 4 by default), provided the FIFO was empty.
  - Full throughput is one operation per cycle.
- FIFO:
  - Registered storage. The head drives resp_y/resp_ovf/resp_tag. resp_valid = (count != 0).
  - Pop on resp_valid & resp_ready.
  - Simultaneous push and pop: count unchanged, both pointers advance. Pop and push of the same entry cannot conflict because a push targets the tail.
  - Pointers wrap modulo FIFO_DEPTH.
- Credit:
  - outstanding = popcount(vsr) + count.
  - req_ready = ~rst & (outstanding < FIFO_DEPTH).
  - req_ready depends on registered state only; there is no combinational path from resp_ready or req_valid.
  - A pop in the current cycle does not raise req_ready until the next cycle.
- Invariants:
  - A push never occurs when count == FIFO_DEPTH. The bench asserts this.
  - Results emerge strictly in issue order.
- Reset mid-operation: all in-flight and queued results are discarded. Nothing appears on resp after rst deasserts until a new issue completes.
- NaN/inf/overflow semantics are entirely fadd's; this block passes fa_y/fa_ovf unmodified.

Optional Feature:
- Macro: FADD_ISSUE_OVF_STICKY_EN.
- When defined, two extra ports are added:
  - ovf_clr, in, 1.
  - ovf_sticky, out, 1.
- ovf_sticky is a register, reset 0. It is set at the edge when a result with fa_ovf = 1 is pushed into the FIFO. It is cleared by ovf_clr. If clear and set occur in the same cycle, set wins.
- When not defined, neither port exists and there is no sticky register.

Test Plan:
- Single add: x1 = 0x3F800000, x2 = 0x40000000, sub = 0, tag = 5, issued in cycle 0, resp_ready = 1 -> resp_valid in cycle 4 with y = 0x40400000, ovf = 0, tag = 5. resp_valid lasts exactly 1 cycle.
- Subtract: x1 = 0x40400000, x2 = 0x3F800000, sub = 1, tag = 9 -> y = 0x40000000, tag = 9. Also check fa_x2 = 0xBF800000 during the issue cycle.
- Backpressure:
  - Stimulus: resp_ready = 0, req_valid held high with tags 1..6.
  - Exactly 4 operations fire and req_ready stays 0 thereafter, no lost or overwritten entries.
  - Release resp_ready -> tags 1,2,3,4 emerge in order. The remaining requests then fire, one per freed credit, one cycle after the corresponding pop.
- Overflow: x1 = x2 = 0x7F7FFFFF, sub = 0 -> y = 0x7F800000, ovf = 1. With the macro defined, ovf_sticky rises the cycle after capture and clears on ovf_clr.
- Reset mid-flight: issue 3 back-to-back ops, assert rst for 1 cycle during cycle 2 -> no resp_valid ever appears for those ops. req_ready = 1 in the first cycle after release, and the next issued op completes normally at +4 cycles.
